serial_byte_receiver: RTL and testbench
=======================================

# serial_byte_receiver

Serial-to-parallel receiver for the MSB-first serial link driven by the team's load-and-shift transmitter. It collects one framed word per `start` pulse, removes the transmitter's +OFFSET encoding, and presents the decoded word on a valid/ready output with overrun detection. It sits at the sink end of the link, feeding downstream byte consumers.

## Interface
- WIDTH, 8, word width in bits; must be at least 2.
- OFFSET, 1, constant that the transmitter adds before sending; it is subtracted on receive.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  frame marker; sampled high in the same cycle as the first (MSB) bit.
- serial_in  input  1  serial data, MSB first, one bit per cycle.
- out_ready  input  1  downstream accepts `data_out` this cycle.
- data_out  output  WIDTH  decoded word; reset value 0.
- data_valid  output  1  `data_out` holds an unconsumed word; reset value 0.
- busy  output  1  a frame is in progress (state SHIFT); reset value 0.
- overrun  output  1  sticky flag: a completed word was dropped; reset value 0; cleared only by `reset`.

## Operation
- There is one clock. Reset is synchronous and active-high, on ports `clk` and `reset`. When `reset` is high at an edge, it overrides every other input.
- The FSM has two states, IDLE and SHIFT. The reset state is IDLE.
- **IDLE:**
  - If `start`=1, set sr[0] to `serial_in`, set cnt to 1, and go to SHIFT.
  - Otherwise, `serial_in` is ignored.
- **SHIFT:**
  - Every cycle, shift `sr` left: sr <= {sr[WIDTH-2:0], serial_in}, and set cnt <= cnt+1.
  - `start` is ignored in SHIFT and is not treated as a new frame.
- **Completion:** the cycle in which cnt==WIDTH-1 captures the LSB.
  - The full word is w = {sr[WIDTH-2:0], serial_in}.
  - The state returns to IDLE.
  - The decoded word is w - OFFSET, computed modulo 2^WIDTH. Wrap-around is silent: with the default parameters, 0x00 decodes to 0xFF.
- **Output slot at completion:**
  - If the slot is empty, or is being consumed this cycle (`data_valid` && `out_ready`): load `data_out` with the decoded word and set `data_valid`=1.
  - If the slot is full and not being consumed: drop the new word, keep `data_out` unchanged, and set `overrun`=1.
- **Handshake:**
  - `data_valid` && `out_ready` at an edge consumes the word.
  - If no completion happens in that same cycle, `data_valid` falls to 0.
  - `data_out` holds its value after it is consumed and while `data_valid`=0.
- `busy` = (state==SHIFT).

## Timing
- Label the `start` edge as k. Bits are sampled at edges k through k+WIDTH-1.
- `data_valid` and `data_out` update at edge k+WIDTH-1 and are visible in the following cycle. The latency is therefore WIDTH cycles from the start edge to valid output.
- Back-to-back frames have no gap: `start` may be asserted at edge k+WIDTH, the first cycle back in IDLE.
- `out_ready` has no combinational path to any output. All outputs are registered.
- Reset in mid-frame abandons the partial word. After reset: state=IDLE, cnt=0, sr=0, and all outputs are 0.
- A `start` pulse arriving at the same edge as `reset` is lost.

## Structure
- A shared package holds:
  - the state enum {IDLE, SHIFT};
  - the default WIDTH and OFFSET constants;
  - a count-width constant, $clog2(WIDTH).
- The top module holds the FSM, the shift register `sr`, and the counter `cnt`.
- One sub-module, `rx_out_slot`: a single-entry valid/ready holding register with overrun detection. Its inputs are load, word and out_ready. Its outputs are data_out, data_valid and overrun.

## Test plan
- Basic frame:
  - Stimulus: after reset, start=1 with the stream 1010_1011 (0xAB) MSB first, and out_ready=1.
  - Response: data_valid=1 for exactly one cycle, beginning 8 cycles after start, with data_out=0xAA.
- Wrap-around:
  - Stimulus: the stream 0x00.
  - Response: data_out=0xFF. Then the stream 0x01 gives data_out=0x00.
- Back-to-back with backpressure:
  - Stimulus: frames 0x11 then 0x22 with no gap; out_ready=0 until after the second frame completes.
  - Response: data_out=0x10 stays held, overrun=1, and data_valid stays 1. After one out_ready cycle, data_valid=0.
- Simultaneous consume and complete:
  - Stimulus: out_ready=1 pulsed at the exact completion edge of the second frame (0x22).
  - Response: data_out goes 0x10 → 0x21, data_valid stays 1, and overrun stays 0.
- Mid-frame reset:
  - Stimulus: reset asserted at bit 4 of a frame, then a clean frame with 0x56.
  - Response: all outputs are 0 after reset, no word is emitted for the aborted frame, and the next output is data_out=0x55.
- start during SHIFT:
  - Stimulus: start held at 1 for all 8 bits of 0x80.
  - Response: exactly one word, 0x7F, and no false re-framing.

Source files
------------

// File: rtl/serial_byte_receiver_pkg.sv
// Shared types and defaults for the serial byte receiver.
// Holds the FSM state enum, default parameters and the counter-width constant.
package serial_byte_receiver_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_OFFSET = 1;
  localparam int CNT_W      = $clog2(DEF_WIDTH);

endpackage

// File: rtl/rx_out_slot.sv
// Single-entry output register with overrun flag; load to data_valid is 1 cycle.
// Accepts a new word when empty or being drained this cycle, else drops it and sets sticky overrun.
module rx_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             consume;

  assign consume = valid_q & out_ready;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/serial_byte_receiver.sv
// MSB-first serial-to-parallel receiver removing the transmitter's +OFFSET; WIDTH cycles start-to-valid.
// Output is a registered valid/ready slot; words completing into a full, undrained slot set overrun.
module serial_byte_receiver
  import serial_byte_receiver_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int OFFSET = DEF_OFFSET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);

  // Counter never narrower than the package default, wider only when WIDTH demands it.
  localparam int CW = (WIDTH > (1 << CNT_W)) ? $clog2(WIDTH) : CNT_W;

  state_e           state_q, state_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] decoded;
  logic             load;

  assign shifted = {sr_q, serial_in};
  assign decoded = shifted - WIDTH'(OFFSET);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = shifted[WIDTH-2:0];
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = shifted[WIDTH-2:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);

  rx_out_slot #(
    .WIDTH(WIDTH)
  ) u_out_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .word       (decoded),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Self-checking bench: directed frames from the test plan plus randomized traffic,
// every cycle compared against a frame-level reference model.
module tb_serial_byte_receiver;

  localparam int W    = 8;
  localparam int OFF  = 1;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset, start, serial_in, out_ready;
  logic [W-1:0] data_out;
  logic         data_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame-level view of the link.
  bit m_inframe;
  int m_nbits;
  int m_acc;
  int m_data;
  bit m_valid;
  bit m_ovr;

  always #5 clk = ~clk;

  serial_byte_receiver #(
    .WIDTH (W),
    .OFFSET(OFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .serial_in  (serial_in),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit st, input bit b, input bit rdy);
    bit done;
    done = 1'b0;
    if (rst) begin
      m_inframe = 1'b0;
      m_nbits   = 0;
      m_acc     = 0;
      m_data    = 0;
      m_valid   = 1'b0;
      m_ovr     = 1'b0;
    end else begin
      if (!m_inframe) begin
        if (st) begin
          m_inframe = 1'b1;
          m_acc     = int'(b);
          m_nbits   = 1;
        end
      end else begin
        m_acc   = m_acc * 2 + int'(b);
        m_nbits = m_nbits + 1;
        if (m_nbits == W) begin
          done      = 1'b1;
          m_inframe = 1'b0;
        end
      end
      if (done) begin
        if (!m_valid || rdy) begin
          m_data  = (m_acc - OFF) & MASK;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1ns after the edge.
  task automatic step(input bit rst, input bit st, input bit b, input bit rdy);
    reset     = rst;
    start     = st;
    serial_in = b;
    out_ready = rdy;
    model_edge(rst, st, b, rdy);
    @(posedge clk);
    #1;
    check_val("data_out",   data_out,   m_data);
    check_val("data_valid", data_valid, int'(m_valid));
    check_val("busy",       busy,       int'(m_inframe));
    check_val("overrun",    overrun,    int'(m_ovr));
  endtask

  task automatic send_frame(input logic [W-1:0] v, input bit hold_start, input logic [W-1:0] rdy_pat);
    for (int i = 0; i < W; i++) begin
      step(1'b0, (i == 0) || hold_start, v[W-1-i], rdy_pat[W-1-i]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("rst_data",    data_out,   0);
    check_val("rst_valid",   data_valid, 0);
    check_val("rst_busy",    busy,       0);
    check_val("rst_overrun", overrun,    0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("rst_start_lost", busy, 0);

    // Basic frame
    send_frame(8'hAB, 1'b0, 8'hFF);
    check_val("basic_data",  data_out,   8'hAA);
    check_val("basic_valid", data_valid, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("basic_one_cycle", data_valid, 0);
    check_val("basic_hold",      data_out,   8'hAA);

    // Wrap-around, back to back
    send_frame(8'h00, 1'b0, 8'hFF);
    check_val("wrap_ff", data_out, 8'hFF);
    send_frame(8'h01, 1'b0, 8'hFF);
    check_val("wrap_00", data_out, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back with backpressure
    send_frame(8'h11, 1'b0, 8'h00);
    check_val("bp_first", data_out, 8'h10);
    send_frame(8'h22, 1'b0, 8'h00);
    check_val("bp_held",    data_out,   8'h10);
    check_val("bp_overrun", overrun,    1);
    check_val("bp_valid",   data_valid, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("bp_drained", data_valid, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("bp_sticky", overrun, 1);

    // Simultaneous consume and complete
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 8'h00);
    send_frame(8'h22, 1'b0, 8'h01);
    check_val("sim_data",    data_out,   8'h21);
    check_val("sim_valid",   data_valid, 1);
    check_val("sim_overrun", overrun,    0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Mid-frame reset
    for (int i = 0; i < 4; i++) step(1'b0, i == 0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_val("mrst_data",  data_out,   0);
    check_val("mrst_valid", data_valid, 0);
    check_val("mrst_busy",  busy,       0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("mrst_no_word", data_valid, 0);
    send_frame(8'h56, 1'b0, 8'hFF);
    check_val("mrst_next", data_out, 8'h55);

    // start held during SHIFT
    send_frame(8'h80, 1'b1, 8'hFF);
    check_val("hold_data", data_out, 8'h7F);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("hold_no_reframe", busy,       0);
    check_val("hold_one_word",   data_valid, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
